// File: rtl/sysid_pkg.sv
// Shared register map and helpers for the system-identification slave.
// Combinational definitions only; no latency.
// No flow control; constants and pure functions.
package sysid_pkg;

  localparam int unsigned OFF_ID        = 0;
  localparam int unsigned OFF_TS        = 1;
  localparam int unsigned OFF_UPTIME_LO = 2;
  localparam int unsigned OFF_UPTIME_HI = 3;
  localparam int unsigned OFF_SCRATCH   = 4;
  localparam int unsigned OFF_CAPS      = 5;
  localparam int unsigned OFF_USER_BASE = 6;

  localparam logic [15:0] CAPS_VERSION = 16'h0001;

  typedef struct packed {
    logic [15:0] version;
    logic [7:0]  rsvd;
    logic [7:0]  num_user;
  } caps_t;

  // Byte-lane merge for partial writes.
  function automatic logic [31:0] apply_be(input logic [31:0] cur,
                                           input logic [31:0] wdat,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wdat[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// 64-bit free-running uptime counter with clear and coherent high-word snapshot.
// Clear takes effect on the next edge; snapshot loads on the edge it is asserted.
// No backpressure; counts every cycle.
module sysid_uptime_ctr
  import sysid_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        snap,
  output logic [31:0] lo,
  output logic [31:0] hi_snap
);

  logic [63:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= '0;
      hi_snap <= '0;
    end else begin
      if (clear) count <= '0;
      else       count <= count + 64'd1;
      // Captured from the same sample as the low word returned by this read.
      if (snap) hi_snap <= count[63:32];
    end
  end

  assign lo = count[31:0];

endmodule

// File: rtl/system_0_sysid_ext.sv
// Avalon-MM identity/health slave: ID, timestamp, uptime, scratch, caps, user words.
// Reads return one cycle after the request with a readdatavalid strobe.
// No waitrequest; every request is accepted in the cycle it is presented.
module system_0_sysid_ext
  import sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE       = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP      = 32'd1739663930,
  parameter int          NUM_USER_WORDS = 4,
  parameter int          ADDR_W         = 4,
  parameter logic [31:0] SCRATCH_RESET  = 32'h0000_0000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           address,
  input  logic                        read,
  input  logic                        write,
  input  logic [31:0]                 writedata,
  input  logic [3:0]                  byteenable,
  output logic [31:0]                 readdata,
  output logic                        readdatavalid,
  input  logic [32*NUM_USER_WORDS-1:0] user_words
);

  logic        rd_fire;
  logic        ctr_clear;
  logic        ctr_snap;
  logic [31:0] ctr_lo;
  logic [31:0] ctr_hi_snap;
  logic [31:0] scratch;
  logic [31:0] rd_mux;
  caps_t       caps;

  // A write wins over a simultaneous read; the read is dropped.
  assign rd_fire   = read && !write;
  assign ctr_clear = write && (address == ADDR_W'(OFF_UPTIME_LO));
  assign ctr_snap  = rd_fire && (address == ADDR_W'(OFF_UPTIME_LO));

  assign caps = '{version: CAPS_VERSION, rsvd: 8'd0, num_user: 8'(NUM_USER_WORDS)};

  sysid_uptime_ctr u_ctr (
    .clock   (clock),
    .reset   (reset),
    .clear   (ctr_clear),
    .snap    (ctr_snap),
    .lo      (ctr_lo),
    .hi_snap (ctr_hi_snap)
  );

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_W'(OFF_ID):        rd_mux = ID_VALUE;
      ADDR_W'(OFF_TS):        rd_mux = TIMESTAMP;
      ADDR_W'(OFF_UPTIME_LO): rd_mux = ctr_lo;
      ADDR_W'(OFF_UPTIME_HI): rd_mux = ctr_hi_snap;
      ADDR_W'(OFF_SCRATCH):   rd_mux = scratch;
      ADDR_W'(OFF_CAPS):      rd_mux = caps;
      default:                rd_mux = '0;
    endcase
    for (int k = 0; k < NUM_USER_WORDS; k++) begin
      if (address == ADDR_W'(OFF_USER_BASE + k)) rd_mux = user_words[32*k +: 32];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      scratch       <= SCRATCH_RESET;
    end else begin
      readdatavalid <= rd_fire;
      if (rd_fire) readdata <= rd_mux;
      if (write && (address == ADDR_W'(OFF_SCRATCH)))
        scratch <= apply_be(scratch, writedata, byteenable);
    end
  end

endmodule
